// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> hazard controller bundle: requests from decode, stall/reset controls back.
// master = decode/pipeline side, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_CLASSES = 4,
    parameter int NUM_EXT     = 3,
    parameter int CNT_W       = 16
);
    logic [NUM_CLASSES-1:0] rd_req;
    logic [NUM_CLASSES-1:0] wr_req;
    logic [NUM_EXT-1:0]     ext_stall;
    logic                   flush_req;
    logic                   flush_ext_en;
    logic                   interrupt;
    logic                   hazard;
    logic [NUM_CLASSES-1:0] hazard_class;
    logic                   decoder_flush;
    logic                   decoder_rst;
    logic [CNT_W-1:0]       stall_cycles;

    modport master (
        output rd_req, wr_req, ext_stall,
        output flush_req, flush_ext_en, interrupt,
        input  hazard, hazard_class, decoder_flush,
        input  decoder_rst, stall_cycles
    );

    modport slave (
        input  rd_req, wr_req, ext_stall,
        input  flush_req, flush_ext_en, interrupt,
        output hazard, hazard_class, decoder_flush,
        output decoder_rst, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// NeonFox RAW scoreboard, stall and decoder flush/reset sequencer.
// Optional stall counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NUM_CLASSES = 4,
    parameter int PIPE_DEPTH  = 3,
    parameter int NUM_EXT     = 3,
    parameter int FLUSH_EXT   = 2,
    parameter int RST_HOLD    = 2,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int HW = $clog2(RST_HOLD + 2);
    localparam int FW = $clog2(FLUSH_EXT + 1);

    logic [NUM_CLASSES-1:0] sb [PIPE_DEPTH];
    logic [NUM_CLASSES-1:0] inflight;
    logic [HW-1:0]          hold_cnt;
    logic [FW-1:0]          flush_cnt;
    logic                   frozen;
    logic                   raw;
    logic                   ext_flush;
    logic                   dec_rst;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            inflight = inflight | sb[k];
        end
    end

    // sb may hold stale entries during the reset cycle itself
    assign bus.hazard_class = rst ? '0 : (bus.rd_req & inflight);
    assign raw              = |bus.hazard_class;
    assign frozen           = |bus.ext_stall;
    assign bus.hazard       = raw | frozen;
    assign ext_flush        = bus.flush_req & bus.flush_ext_en;
    assign bus.decoder_flush = bus.flush_req;

    assign dec_rst = rst
                   | (hold_cnt != '0)
                   | (flush_cnt != '0)
                   | bus.interrupt
                   | ext_flush;
    assign bus.decoder_rst = dec_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sb[k] <= '0;
            end
            hold_cnt  <= HW'(RST_HOLD);
            flush_cnt <= '0;
        end else if (!frozen) begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= (raw | dec_rst | bus.flush_req) ? '0 : bus.wr_req;
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (ext_flush) begin
                flush_cnt <= FW'(FLUSH_EXT - 1);
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.hazard && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random + directed check of hazard_scoreboard against a timestamp-based model.
// Model counts unfrozen cycles and remembers when each class was last written.
module tb_hazard_scoreboard;
    localparam int NC = 4;
    localparam int PD = 3;
    localparam int NE = 3;
    localparam int FE = 2;
    localparam int RH = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_CLASSES(NC), .NUM_EXT(NE), .CNT_W(CW)) bus ();

    hazard_scoreboard #(
        .NUM_CLASSES(NC), .PIPE_DEPTH(PD), .NUM_EXT(NE),
        .FLUSH_EXT(FE), .RST_HOLD(RH), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // model state: time measured in unfrozen cycles
    int      ucount;
    int      last_wr [NC];
    int      rst_mark;
    int      flush_mark;
    longint  perf;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input logic [NC-1:0] rd, input logic [NC-1:0] wr,
                       input logic [NE-1:0] ext, input logic fl,
                       input logic fe, input logic intr, input logic r);
        logic [NC-1:0] hc;
        logic          frz;
        logic          raw;
        logic          hz;
        logic          drst;
        int            age;
        @(negedge clk);
        rst              = r;
        bus.rd_req       = rd;
        bus.wr_req       = wr;
        bus.ext_stall    = ext;
        bus.flush_req    = fl;
        bus.flush_ext_en = fe;
        bus.interrupt    = intr;
        frz = |ext;
        hc  = '0;
        if (!r) begin
            for (int c = 0; c < NC; c++) begin
                age = ucount - last_wr[c];
                hc[c] = rd[c] && age >= 1 && age <= PD;
            end
        end
        raw  = |hc;
        hz   = raw | frz;
        age  = ucount - flush_mark;
        drst = r || (ucount - rst_mark < RH) || (age >= 1 && age <= FE - 1)
               || intr || (fl && fe);
        #1;
        check("hazard", 64'(bus.hazard), 64'(hz));
        check("hazard_class", 64'(bus.hazard_class), 64'(hc));
        check("decoder_flush", 64'(bus.decoder_flush), 64'(fl));
        check("decoder_rst", 64'(bus.decoder_rst), 64'(drst));
        check("stall_cycles", 64'(bus.stall_cycles), 64'(perf));
        @(posedge clk);
        if (r) begin
            rst_mark   = ucount;
            flush_mark = -100000;
            for (int c = 0; c < NC; c++) last_wr[c] = -100000;
            perf = 0;
        end else begin
`ifdef HAZARD_PERF_EN
            if (hz && perf < (64'd1 << CW) - 1) perf++;
`endif
            if (!frz) begin
                if (!(raw || drst || fl)) begin
                    for (int c = 0; c < NC; c++) begin
                        if (wr[c]) last_wr[c] = ucount;
                    end
                end
                if (fl && fe) flush_mark = ucount;
                ucount++;
            end
        end
    endtask

    initial begin
        ucount     = 0;
        rst_mark   = -100000;
        flush_mark = -100000;
        perf       = 0;
        for (int c = 0; c < NC; c++) last_wr[c] = -100000;

        // reset then idle: decoder held in reset two extra cycles
        cyc(4'h0, 4'h0, 3'b000, 0, 0, 0, 1);
        repeat (4) cyc(4'h0, 4'h0, 3'b000, 0, 0, 0, 0);
        // RAW window of PIPE_DEPTH cycles
        cyc(4'h0, 4'h1, 3'b000, 0, 0, 0, 0);
        repeat (5) cyc(4'h1, 4'h0, 3'b000, 0, 0, 0, 0);
        // same window stretched by an external stall
        cyc(4'h0, 4'h1, 3'b000, 0, 0, 0, 0);
        cyc(4'h1, 4'h0, 3'b000, 0, 0, 0, 0);
        repeat (3) cyc(4'h1, 4'h0, 3'b001, 0, 0, 0, 0);
        repeat (4) cyc(4'h1, 4'h0, 3'b000, 0, 0, 0, 0);
        // extended flush drops a same-cycle write
        cyc(4'h0, 4'h2, 3'b000, 1, 1, 0, 0);
        repeat (3) cyc(4'h2, 4'h0, 3'b000, 0, 0, 0, 0);
        // interrupt pulse and a plain flush
        cyc(4'h0, 4'h0, 3'b000, 0, 0, 1, 0);
        cyc(4'h0, 4'h0, 3'b000, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 3'b000, 1, 0, 0, 0);
        cyc(4'h0, 4'h0, 3'b000, 0, 0, 0, 0);
        // reset mid-stall and mid-flush
        cyc(4'h0, 4'h4, 3'b000, 0, 0, 0, 0);
        cyc(4'h4, 4'h0, 3'b000, 1, 1, 0, 0);
        cyc(4'h4, 4'h0, 3'b010, 0, 0, 0, 1);
        repeat (4) cyc(4'h4, 4'h0, 3'b000, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(NC'($urandom), NC'($urandom),
                ($urandom_range(0, 5) == 0) ? NE'($urandom) : '0,
                $urandom_range(0, 9) == 0, 1'($urandom),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
